// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED pattern controller.
//   mode_t        : 2-bit display mode selector
//   MODE_*        : mode encodings (ONEHOT, BAR, BLINK, CHASE)
//   tick_div()    : clock cycles per animation tick (CLK_HZ / TICK_HZ)
package led_ctrl_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_ONEHOT = 2'd0;
    localparam mode_t MODE_BAR    = 2'd1;
    localparam mode_t MODE_BLINK  = 2'd2;
    localparam mode_t MODE_CHASE  = 2'd3;

    // Number of system clock cycles between animation ticks.
    function automatic int tick_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_tick.sv
// Animation tick generator.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   run    : counter advances while high; held at 0 while low
//   clr    : synchronous clear (restart of the animation), wins over run
//   o_tick : high for one cycle every CLK_HZ/TICK_HZ running cycles
module led_tick_gen
    import led_ctrl_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic o_tick
);

    localparam int DIV   = tick_div(CLK_HZ, TICK_HZ);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic             at_end;

    assign at_end = (cnt == CNT_W'(DIV - 1));

    // Gated by run so the pulse drops the moment the animation stops,
    // never lingering high while idle.
    assign o_tick = run && at_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || clr) begin
            cnt <= '0;
        end else if (at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern driver: shows a captured value on NUM_LED LEDs as one-hot,
// bar graph, blinking one-hot or a running chase light.
//   clk          : system clock, rising edge
//   rst_n        : asynchronous active-low reset
//   i_en         : display enable; low blanks the LEDs and restarts animation
//   i_mode       : 0 ONEHOT, 1 BAR, 2 BLINK, 3 CHASE
//   i_data_valid : capture strobe for i_led_data
//   i_led_data   : value to display
//   o_led_data   : registered LED drive, bit0 = LED1
//   o_tick       : one-cycle animation tick pulse
//
// Data interface: i_data_valid is a one-cycle strobe with no back-pressure;
// i_led_data is sampled on every rising edge where i_data_valid is high,
// regardless of i_en, and the new value reaches o_led_data one edge later.
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 10,
    parameter int NUM_LED = 9,
    parameter int DATA_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic [1:0]         i_mode,
    input  logic               i_data_valid,
    input  logic [DATA_W-1:0]  i_led_data,
    output logic [NUM_LED-1:0] o_led_data,
    output logic               o_tick
);

    localparam int POS_W = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;

    logic [DATA_W-1:0]  r_value;
    mode_t              r_mode;
    logic               phase;
    logic [POS_W-1:0]   pos;
    logic               tick;
    logic               mode_chg;
    logic               timed;
    logic               run;
    logic [NUM_LED-1:0] pattern;
    int                 v_int;
    int                 pos_int;

    assign mode_chg = (r_mode != i_mode);
    assign timed    = (r_mode == MODE_BLINK) || (r_mode == MODE_CHASE);
    assign run      = i_en && timed;
    assign v_int    = int'(r_value);
    assign pos_int  = int'(pos);
    assign o_tick   = tick;

    led_tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .clr    (mode_chg),
        .o_tick (tick)
    );

    // Pattern decode from the registered state.
    always_comb begin
        logic [NUM_LED-1:0] onehot;
        logic [NUM_LED-1:0] bar;
        logic [NUM_LED-1:0] chase;
        onehot  = '0;
        bar     = '0;
        chase   = '0;
        pattern = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            onehot[i] = (v_int == i + 1);
            bar[i]    = (v_int > i);
            chase[i]  = (pos_int == i);
        end
        case (r_mode)
            MODE_ONEHOT: pattern = onehot;
            MODE_BAR:    pattern = bar;
            MODE_BLINK:  pattern = phase ? onehot : '0;
            MODE_CHASE:  pattern = (r_value != '0) ? chase : '0;
            default:     pattern = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value    <= '0;
            r_mode     <= MODE_ONEHOT;
            phase      <= 1'b0;
            pos        <= '0;
            o_led_data <= '0;
        end else begin
            if (i_data_valid) begin
                r_value <= i_led_data;
            end
            r_mode <= i_mode;
            // Disable or a mode switch restarts the animation; this takes
            // priority over a tick landing in the same cycle.
            if (!i_en || mode_chg) begin
                phase <= 1'b0;
                pos   <= '0;
            end else begin
                if (tick && (r_mode == MODE_BLINK)) begin
                    phase <= ~phase;
                end
                // A zero value pauses the chase at its current position.
                if (tick && (r_mode == MODE_CHASE) && (r_value != '0)) begin
                    pos <= (pos == POS_W'(NUM_LED - 1)) ? '0 : pos + POS_W'(1);
                end
            end
            o_led_data <= i_en ? pattern : '0;
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
module tb_led_pattern_ctrl;

  localparam int CLK_HZ  = 100;
  localparam int TICK_HZ = 10;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int NL      = 9;
  localparam int DW      = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_en = 1'b0;
  logic [1:0]    i_mode = 2'd0;
  logic          i_data_valid = 1'b0;
  logic [DW-1:0] i_led_data = '0;
  logic [NL-1:0] o_led_data;
  logic          o_tick;

  always #5 clk = ~clk;

  led_pattern_ctrl #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .NUM_LED (NL),
    .DATA_W  (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (i_en),
    .i_mode       (i_mode),
    .i_data_valid (i_data_valid),
    .i_led_data   (i_led_data),
    .o_led_data   (o_led_data),
    .o_tick       (o_tick)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [NL:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Animation is described by counts since the last restart: running cycles
  // elapsed, ticks seen, and chase steps taken.  Blink phase is the tick
  // count parity, chase position is the step count modulo the LED count.
  int m_value = 0;
  int m_mode = 0;
  int m_elapsed = 0;
  int m_nticks = 0;
  int m_steps = 0;
  logic [NL-1:0] m_led = '0;

  function automatic bit is_timed(input int mode);
    return (mode == 2) || (mode == 3);
  endfunction

  function automatic logic [NL-1:0] onehot_of(input int v);
    if (v >= 1 && v <= NL) return NL'(1 << (v - 1));
    return '0;
  endfunction

  function automatic logic [NL-1:0] pat(input int v, input int mode, input int nticks, input int steps);
    int n;
    case (mode)
      0: return onehot_of(v);
      1: begin
        n = (v < NL) ? v : NL;
        return NL'((1 << n) - 1);
      end
      2: return (nticks % 2 == 1) ? onehot_of(v) : '0;
      default: return (v == 0) ? '0 : NL'(1 << (steps % NL));
    endcase
  endfunction

  task automatic model_reset();
    m_value = 0; m_mode = 0; m_elapsed = 0; m_nticks = 0; m_steps = 0; m_led = '0;
  endtask

  always @(posedge clk) begin
    bit en_s, vl_s, tk, tick_pred;
    int md_s, dv_s;
    en_s = i_en; md_s = int'(i_mode); vl_s = i_data_valid; dv_s = int'(i_led_data);
    if (rst_n) begin
      tk = en_s && is_timed(m_mode) && (m_elapsed % DIV == DIV - 1);
      m_led = en_s ? pat(m_value, m_mode, m_nticks, m_steps) : '0;
      if (!en_s || md_s != m_mode) begin
        m_elapsed = 0; m_nticks = 0; m_steps = 0;
      end else if (is_timed(m_mode)) begin
        m_elapsed++;
        if (tk) begin
          m_nticks++;
          if (m_mode == 3 && m_value != 0) m_steps++;
        end
      end
      if (vl_s) m_value = dv_s;
      m_mode = md_s;
    end
    #2;
    if (!rst_n) model_reset();
    tick_pred = rst_n && i_en && is_timed(m_mode) && (m_elapsed % DIV == DIV - 1);
    exp_q.push_back({tick_pred, m_led});
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [NL:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("led", 32'(o_led_data), 32'(e[NL-1:0]));
      check("tick", 32'(o_tick), 32'(e[NL]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input int v);
    i_data_valid = 1'b1;
    i_led_data   = DW'(v);
    step(1);
    i_data_valid = 1'b0;
  endtask

  task automatic wait_tick(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3 * DIV; k++) begin
      if (o_tick) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_led(input string name, input logic [NL-1:0] want, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (o_led_data == want) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    step(3);
    rst_n = 1'b1;
    step(2);

    // one-hot sweep over every value, in random order after a linear pass
    i_en = 1'b1; i_mode = 2'd0;
    for (int v = 0; v < 16; v++) begin
      strobe(v);
      step(2);
    end
    strobe(3); step(1);
    check("onehot_v3", 32'(o_led_data), 32'h004);
    strobe(9); step(1);
    check("onehot_v9", 32'(o_led_data), 32'h100);
    for (int k = 0; k < 10; k++) begin
      strobe($urandom_range(0, 15));
      step($urandom_range(0, 2));
    end

    // bar graph including saturation and zero
    i_mode = 2'd1; step(1);
    strobe(4); step(1);
    check("bar_v4", 32'(o_led_data), 32'h00F);
    strobe(12); step(1);
    check("bar_v12", 32'(o_led_data), 32'h1FF);
    strobe(0); step(1);
    check("bar_v0", 32'(o_led_data), 32'h000);
    for (int k = 0; k < 8; k++) begin
      strobe($urandom_range(0, 15));
      step(2);
    end

    // blink, then disable and re-enable
    i_mode = 2'd2;
    strobe(2);
    step(45);
    i_en = 1'b0; step(1);
    check("blink_off", 32'(o_led_data), 32'h000);
    step(14);
    i_en = 1'b1; step(30);

    // valid strobe landing on a tick in blink mode
    wait_tick("blink_tick_wait");
    i_data_valid = 1'b1; i_led_data = 4'd7;
    step(1);
    i_data_valid = 1'b0;
    step(30);

    // chase with wrap, then a pause at v=0
    i_mode = 2'd3;
    strobe(1);
    step(105);
    strobe(0); step(30);
    strobe(5); step(20);

    // mode change to BAR on a tick cycle: no step, bar shown 2 edges later
    strobe(1);
    wait_tick("chase_tick_wait");
    i_mode = 2'd1;
    step(2);
    check("chase_to_bar", 32'(o_led_data), 32'h001);

    // async reset in the middle of a chase at position 5
    i_mode = 2'd3;
    strobe(1);
    wait_led("chase_pos5_wait", 9'h020, 90);
    rst_n = 1'b0;
    #1;
    check("rst_led", 32'(o_led_data), 32'h000);
    check("rst_tick", 32'(o_tick), 32'h0);
    step(3);
    rst_n = 1'b1;
    strobe(1);
    step(1);
    check("rst_restart", 32'(o_led_data), 32'h001);
    step(25);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      i_en = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 39) == 0) i_mode = 2'($urandom_range(0, 3));
      i_data_valid = ($urandom_range(0, 9) == 0);
      i_led_data = DW'($urandom_range(0, 15));
      step(1);
    end
    i_data_valid = 1'b0;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
